// File: rtl/instr_pkg.sv
// Shared encodings for the instruction-stream encoder and the control decoder.
package instr_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LI    = 6'h3F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;

  typedef enum logic [2:0] {
    CMD_ADD = 3'd0,
    CMD_SUB = 3'd1,
    CMD_AND = 3'd2,
    CMD_OR  = 3'd3,
    CMD_SLL = 3'd4,
    CMD_SRL = 3'd5,
    CMD_ILL = 3'd6,
    CMD_LI  = 3'd7
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/instr_encoder_if.sv
// Command handshake plus instruction-memory write port.
// master = host/loader side, slave = encoder side.
interface instr_encoder_if #(parameter int AW = 5);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [2:0]      cmd_op;
  logic [4:0]      cmd_rd;
  logic [4:0]      cmd_rs;
  logic [4:0]      cmd_rt;
  logic [4:0]      cmd_shamt;
  logic [15:0]     cmd_imm;
  logic            im_we;
  logic            im_ready;
  logic [AW-1:0]   im_addr;
  logic [31:0]     im_wdata;

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_rt, cmd_shamt, cmd_imm, im_ready,
    input  cmd_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_rt, cmd_shamt, cmd_imm, im_ready,
    output cmd_ready, im_we, im_addr, im_wdata
  );
endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO; head entry reads as zero while empty.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW:0]      cnt;
  logic             do_push, do_pop;

  // a pop frees a slot in the same cycle, so push is legal when full and popping
  assign do_push = push && !clr && (!full || pop);
  assign do_pop  = pop && !clr && !empty;

  // pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // storage, no reset needed since empty masks the head
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign full  = (cnt == (PW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;
  assign dout  = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/instr_encoder.sv
// Encodes symbolic commands into 32-bit instruction words and streams them
// into consecutive instruction-memory addresses through a small FIFO.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | after reset, nothing accepted or written
// ST_LOAD  | accepting commands and writing words
// ST_DRAIN | no more commands, writing out buffered words
// ST_DONE  | all words written, waiting for start
module instr_encoder
  import instr_pkg::*;
#(
  parameter int AW    = 5,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                finish,
  instr_encoder_if.slave      bus,
  output logic [AW:0]         count,
  output logic                done,
  output logic                err
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [AW+1:0] CAP = (AW+2)'(2**AW);

  state_e          state_q, state_d;
  cmd_op_e         op;
  logic [AW-1:0]   addr_q;
  logic [AW:0]     count_q;
  logic            err_q;
  logic            fifo_full, fifo_empty;
  logic [PW:0]     fifo_cnt;
  logic [31:0]     enc_word;
  logic            ready, we, accept, push, pop;
  logic [AW+1:0]   total;

  function automatic logic [31:0] encode(cmd_op_e f_op, logic [4:0] rd, logic [4:0] rs,
                                         logic [4:0] rt, logic [4:0] sh, logic [15:0] imm);
    case (f_op)
      CMD_ADD: encode = {OP_RTYPE, rs, rt, rd, 5'd0, FN_ADD};
      CMD_SUB: encode = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SUB};
      CMD_AND: encode = {OP_RTYPE, rs, rt, rd, 5'd0, FN_AND};
      CMD_OR:  encode = {OP_RTYPE, rs, rt, rd, 5'd0, FN_OR};
      CMD_SLL: encode = {OP_RTYPE, 5'd0, rt, rd, sh, FN_SLL};
      CMD_SRL: encode = {OP_RTYPE, 5'd0, rt, rd, sh, FN_SRL};
      CMD_LI:  encode = {OP_LI, 5'd0, rd, imm};
      default: encode = '0;
    endcase
  endfunction

  assign op       = cmd_op_e'(bus.cmd_op);
  assign enc_word = encode(op, bus.cmd_rd, bus.cmd_rs, bus.cmd_rt, bus.cmd_shamt, bus.cmd_imm);

  // words already written plus words buffered: the capacity check must count both
  assign total  = (AW+2)'(count_q) + (AW+2)'(fifo_cnt);
  // registered full only, so im_ready never reaches cmd_ready combinationally
  assign ready  = (state_q == ST_LOAD) && !fifo_full && (total < CAP);
  assign we     = !fifo_empty && ((state_q == ST_LOAD) || (state_q == ST_DRAIN));
  assign accept = bus.cmd_valid && ready && !start;
  assign push   = accept && (op != CMD_ILL);
  assign pop    = we && bus.im_ready && !start;

  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .push  (push),
    .pop   (pop),
    .din   (enc_word),
    .dout  (bus.im_wdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // next-state logic; start overrides everything
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_LOAD:  if (finish || (total + (AW+2)'(push)) == CAP) state_d = ST_DRAIN;
        ST_DRAIN: if (fifo_empty || (fifo_cnt == (PW+1)'(1) && pop)) state_d = ST_DONE;
        default:  state_d = state_q;
      endcase
    end
  end

  // address, written-word count and sticky illegal-op flag
  always_ff @(posedge clk) begin
    if (!rst_n || start) begin
      addr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (pop) begin
        addr_q  <= addr_q + 1'b1;
        count_q <= count_q + 1'b1;
      end
      if (accept && op == CMD_ILL) err_q <= 1'b1;
    end
  end

  assign bus.cmd_ready = ready;
  assign bus.im_we     = we;
  assign bus.im_addr   = addr_q;
  assign count         = count_q;
  assign done          = (state_q == ST_DONE);
  assign err           = err_q;
endmodule
